i2s_frame_controller: RTL and testbench
=======================================

Name: i2s_frame_controller

Overview:
Master-mode I2S frame controller. Generates the codec bit clock and LR clock from i_clock, sequences start-up (settle frames) and shutdown (end of current frame), and hands the Deserializer block's left/right words downstream over a valid/ready interface with overrun flagging. The Deserializer consumes o_codec_bit_clock / o_codec_lr_clock directly; the codec sees the same clocks.

Parameters:
CLOCK_DIVIDE, 8, i_clock cycles per BCLK half-period; legal range >= 4 (Deserializer sync + edge detect).
BITS_PER_CHANNEL, 32, BCLK periods per LR half-frame; must be >= SAMPLE_WIDTH + 2.
SAMPLE_WIDTH, 24, width of left/right sample words.
SETTLE_FRAMES, 16, frames discarded after enable before RUN; 0 is legal.

Ports:
i_clock  in  1  system clock.
i_reset  in  1  asynchronous, active-high reset.
i_enable  in  1  level; 1 = run the interface.
o_codec_bit_clock  out  1  generated BCLK.
o_codec_lr_clock  out  1  generated LRCLK; 0 = left, 1 = right.
i_data_left  in  SAMPLE_WIDTH  left word from Deserializer.
i_data_right  in  SAMPLE_WIDTH  right word from Deserializer.
i_data_valid  in  1  one-cycle strobe from Deserializer.
o_sample_left  out  SAMPLE_WIDTH  buffered left sample.
o_sample_right  out  SAMPLE_WIDTH  buffered right sample.
o_sample_valid  out  1  buffer holds an unconsumed sample.
i_sample_ready  in  1  downstream accepts when high with o_sample_valid.
o_overrun  out  1  sticky: a sample was dropped.
i_overrun_clear  in  1  clears o_overrun.
o_running  out  1  high in RUN only.

Behaviour:
- Reset (async, immediate): state IDLE; BCLK 0, LRCLK 1, divider 0, bit_index 2*BITS_PER_CHANNEL-1, settle count 0; o_sample_* 0, o_sample_valid 0, o_overrun 0, o_running 0.
- Divider: active outside IDLE. Counts 0..CLOCK_DIVIDE-1. At CLOCK_DIVIDE-1 it wraps and toggles BCLK. BCLK period is 2*CLOCK_DIVIDE cycles. The first rising edge occurs CLOCK_DIVIDE cycles after leaving IDLE.
- bit_index: advances on each BCLK falling edge, modulo 2*BITS_PER_CHANNEL. LRCLK is registered on the same edge as (new bit_index >= BITS_PER_CHANNEL). It starts at 2*BITS_PER_CHANNEL-1, so the first falling edge wraps to 0 and drops LRCLK. Frame = 2*BITS_PER_CHANNEL*2*CLOCK_DIVIDE cycles (1024 at defaults).
- lr_fall strobe: asserted on each wrap to 0.
- States:
  - IDLE: clocks held (BCLK 0, LRCLK 1). i_enable=1 -> SETTLE.
  - SETTLE: clocks run; counts lr_fall strobes. On strobe number SETTLE_FRAMES+1 -> RUN. i_enable=0 -> STOP. i_data_valid is ignored.
  - RUN: o_running=1; sample handoff active. i_enable=0 -> STOP.
  - STOP: clocks run until bit_index = 2*BITS_PER_CHANNEL-1. On the next BCLK falling edge, the wrap is suppressed: BCLK 0, LRCLK 1, divider 0 -> IDLE. i_enable is ignored in STOP, including re-assertion; handoff is inactive.
- Handoff (RUN only), on i_data_valid:
  - Buffer empty, or (o_sample_valid & i_sample_ready) this cycle: load both words; o_sample_valid=1 next cycle.
  - Otherwise: drop the new words, keep the buffer, set o_overrun.
- Without i_data_valid, o_sample_valid & i_sample_ready clears o_sample_valid next cycle.
- A buffered sample survives STOP/IDLE until consumed or reset.
- Overrun set and i_overrun_clear in the same cycle: set wins.
- Handoff latency: one cycle from i_data_valid to o_sample_valid.

Decomposition:
- Package i2s_pkg: state enum (IDLE, SETTLE, RUN, STOP) and the default SAMPLE_WIDTH constant.
- Sub-module i2s_clock_generator: divider, bit_index, BCLK/LRCLK registers, lr_fall strobe, with run/stop_at_frame_end inputs.
- The parent holds the FSM, settle counter and sample buffer.

Test Plan:
- Reset, CLOCK_DIVIDE=4, BITS_PER_CHANNEL=32, enable -> BCLK period 8 cycles; LRCLK falls at cycle 8 after SETTLE entry; LRCLK low for 256 cycles, then high for 256.
- SETTLE_FRAMES=2, i_data_valid pulses in frames 0-1 -> no o_sample_valid; o_running rises on the third lr_fall.
- RUN, i_data_valid with left 0x123456, right 0xABCDEF, ready=1 -> next cycle o_sample_valid=1 with those values; cleared the cycle after the handshake.
- ready=0 with two valid pulses (0x000001 then 0x000002) -> buffer keeps 0x000001, o_overrun=1. Clear together with a third overflow -> remains 1. Clear alone -> 0.
- Drop i_enable at bit_index 10 -> clocks continue to bit_index 63; at the next falling edge BCLK=0, LRCLK=1, IDLE. Re-enable -> SETTLE restarts from bit_index 63.
- Assert i_reset mid-RUN with a buffered sample -> all outputs take reset values without waiting for an i_clock edge.
- Loopback: controller clocks drive the Deserializer plus a codec model sending left 0x7FFFFF / right 0x800000 -> o_sample_left/right match every frame after settle.

Source files
------------

// File: rtl/i2s_pkg.sv
// Shared types and defaults for the I2S frame controller.
package i2s_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        RUN,
        STOP
    } i2s_state_t;

    localparam int DEFAULT_SAMPLE_WIDTH = 24;

endpackage

// File: rtl/i2s_clock_generator.sv
// BCLK/LRCLK generation for master-mode I2S: divider, bit index within the frame,
// frame-wrap strobe, and a suppressed wrap that parks the clocks at frame end.
module i2s_clock_generator #(
    parameter int CLOCK_DIVIDE     = 8,
    parameter int BITS_PER_CHANNEL = 32
) (
    input  logic i_clock,
    input  logic i_reset,
    input  logic run,
    input  logic stop_at_frame_end,
    output logic bit_clock,
    output logic lr_clock,
    output logic lr_fall,
    output logic stopped
);

    localparam int FRAME_BITS = 2 * BITS_PER_CHANNEL;
    localparam int DIV_W      = $clog2(CLOCK_DIVIDE);
    localparam int IDX_W      = $clog2(FRAME_BITS);

    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLOCK_DIVIDE - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(FRAME_BITS - 1);
    localparam logic [IDX_W-1:0] IDX_RIGHT = IDX_W'(BITS_PER_CHANNEL);

    logic [DIV_W-1:0] divider;
    logic [IDX_W-1:0] bit_index;
    logic [IDX_W-1:0] next_index;
    logic             fall_edge;

    assign fall_edge  = run && (divider == DIV_LAST) && bit_clock;
    assign next_index = (bit_index == IDX_LAST) ? '0 : bit_index + 1'b1;
    // Last falling edge of the frame while stopping: the wrap to bit 0 never happens.
    assign stopped    = fall_edge && stop_at_frame_end && (bit_index == IDX_LAST);
    assign lr_fall    = fall_edge && !stop_at_frame_end && (bit_index == IDX_LAST);

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            divider   <= '0;
            bit_clock <= 1'b0;
            lr_clock  <= 1'b1;
            bit_index <= IDX_LAST;
        end else if (!run) begin
            divider   <= '0;
            bit_clock <= 1'b0;
            lr_clock  <= 1'b1;
        end else if (divider == DIV_LAST) begin
            divider <= '0;
            if (stopped) begin
                bit_clock <= 1'b0;
                lr_clock  <= 1'b1;
            end else begin
                bit_clock <= !bit_clock;
                if (bit_clock) begin
                    bit_index <= next_index;
                    lr_clock  <= (next_index >= IDX_RIGHT);
                end
            end
        end else begin
            divider <= divider + 1'b1;
        end
    end

endmodule

// File: rtl/i2s_frame_controller.sv
// Master-mode I2S frame controller: start-up/shutdown sequencing around the clock
// generator and a one-entry left/right sample buffer with sticky overrun.
module i2s_frame_controller
    import i2s_pkg::*;
#(
    parameter int CLOCK_DIVIDE     = 8,
    parameter int BITS_PER_CHANNEL = 32,
    parameter int SAMPLE_WIDTH     = DEFAULT_SAMPLE_WIDTH,
    parameter int SETTLE_FRAMES    = 16
) (
    input  logic                    i_clock,
    input  logic                    i_reset,
    input  logic                    i_enable,
    output logic                    o_codec_bit_clock,
    output logic                    o_codec_lr_clock,
    input  logic [SAMPLE_WIDTH-1:0] i_data_left,
    input  logic [SAMPLE_WIDTH-1:0] i_data_right,
    input  logic                    i_data_valid,
    output logic [SAMPLE_WIDTH-1:0] o_sample_left,
    output logic [SAMPLE_WIDTH-1:0] o_sample_right,
    output logic                    o_sample_valid,
    input  logic                    i_sample_ready,
    output logic                    o_overrun,
    input  logic                    i_overrun_clear,
    output logic                    o_running
);

    localparam int SETTLE_W = $clog2(SETTLE_FRAMES + 2);
    localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_FRAMES);

    i2s_state_t          state;
    logic [SETTLE_W-1:0] settle_count;
    logic                lr_fall;
    logic                stopped;

    i2s_clock_generator #(
        .CLOCK_DIVIDE     (CLOCK_DIVIDE),
        .BITS_PER_CHANNEL (BITS_PER_CHANNEL)
    ) u_clock_generator (
        .i_clock           (i_clock),
        .i_reset           (i_reset),
        .run               (state != IDLE),
        .stop_at_frame_end (state == STOP),
        .bit_clock         (o_codec_bit_clock),
        .lr_clock          (o_codec_lr_clock),
        .lr_fall           (lr_fall),
        .stopped           (stopped)
    );

    // Settle counts completed frames; the (SETTLE_FRAMES+1)-th wrap enters RUN.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state        <= IDLE;
            settle_count <= '0;
            o_running    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    settle_count <= '0;
                    if (i_enable) state <= SETTLE;
                end
                SETTLE: begin
                    if (!i_enable) begin
                        state <= STOP;
                    end else if (lr_fall) begin
                        if (settle_count == SETTLE_LAST) begin
                            state     <= RUN;
                            o_running <= 1'b1;
                        end else begin
                            settle_count <= settle_count + 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (!i_enable) begin
                        state     <= STOP;
                        o_running <= 1'b0;
                    end
                end
                STOP: begin
                    if (stopped) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Handshake: a sample moves downstream on every cycle where o_sample_valid and
    // i_sample_ready are both high; o_sample_valid never drops without that handshake
    // (or reset), and the buffered words stay stable while it is high.
    logic handoff;
    logic accept;
    logic take;

    assign take    = o_sample_valid && i_sample_ready;
    assign handoff = (state == RUN) && i_data_valid;
    assign accept  = handoff && (!o_sample_valid || i_sample_ready);

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            o_sample_left  <= '0;
            o_sample_right <= '0;
            o_sample_valid <= 1'b0;
            o_overrun      <= 1'b0;
        end else begin
            if (accept) begin
                o_sample_left  <= i_data_left;
                o_sample_right <= i_data_right;
                o_sample_valid <= 1'b1;
            end else if (take) begin
                o_sample_valid <= 1'b0;
            end
            if (handoff && !accept) begin
                o_overrun <= 1'b1;
            end else if (i_overrun_clear) begin
                o_overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_i2s_frame_controller.sv
// Bench for i2s_frame_controller: clock timeline from frame arithmetic, and a
// one-slot mailbox scoreboard for the sample handoff.
module tb_i2s_frame_controller;

    localparam int CD        = 4;
    localparam int BPC       = 32;
    localparam int SW        = 24;
    localparam int SF        = 2;
    localparam int FB        = 2 * BPC;
    localparam int BIT_CYC   = 2 * CD;
    localparam int FRAME_CYC = FB * BIT_CYC;
    localparam int RUN_EDGE  = BIT_CYC + SF * FRAME_CYC;
    localparam int NEVER     = 1 << 30;

    logic          i_clock = 1'b0;
    logic          i_reset;
    logic          i_enable;
    logic          o_codec_bit_clock;
    logic          o_codec_lr_clock;
    logic [SW-1:0] i_data_left;
    logic [SW-1:0] i_data_right;
    logic          i_data_valid;
    logic [SW-1:0] o_sample_left;
    logic [SW-1:0] o_sample_right;
    logic          o_sample_valid;
    logic          i_sample_ready;
    logic          o_overrun;
    logic          i_overrun_clear;
    logic          o_running;

    i2s_frame_controller #(
        .CLOCK_DIVIDE     (CD),
        .BITS_PER_CHANNEL (BPC),
        .SAMPLE_WIDTH     (SW),
        .SETTLE_FRAMES    (SF)
    ) dut (
        .i_clock           (i_clock),
        .i_reset           (i_reset),
        .i_enable          (i_enable),
        .o_codec_bit_clock (o_codec_bit_clock),
        .o_codec_lr_clock  (o_codec_lr_clock),
        .i_data_left       (i_data_left),
        .i_data_right      (i_data_right),
        .i_data_valid      (i_data_valid),
        .o_sample_left     (o_sample_left),
        .o_sample_right    (o_sample_right),
        .o_sample_valid    (o_sample_valid),
        .i_sample_ready    (i_sample_ready),
        .o_overrun         (o_overrun),
        .i_overrun_clear   (i_overrun_clear),
        .o_running         (o_running)
    );

    // Clock and cycle counter
    always #5 i_clock = ~i_clock;

    int cyc = 0;
    always @(posedge i_clock) cyc <= cyc + 1;

    // Reference state
    logic [2*SW-1:0] exp_q[$];
    int checks     = 0;
    int failures   = 0;
    int e0         = NEVER;
    int stop_req_n = NEVER;
    int end_n      = NEVER;
    bit clk_on     = 1'b0;
    bit mon_on     = 1'b0;
    bit slot_full  = 1'b0;
    bit model_ov   = 1'b0;
    bit drop_now   = 1'b0;

    function automatic int exp_bit(input int n);
        if (n < BIT_CYC) return FB - 1;
        return ((n - BIT_CYC) / BIT_CYC) % FB;
    endfunction

    function automatic logic exp_bclk(input int n);
        return ((n / CD) % 2) == 1;
    endfunction

    function automatic logic exp_lr(input int n);
        return exp_bit(n) >= BPC;
    endfunction

    function automatic logic in_run(input int n);
        return (n >= RUN_EDGE) && (n < stop_req_n);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_reset_values();
        check("rst_bclk", o_codec_bit_clock, 1'b0);
        check("rst_lrclk", o_codec_lr_clock, 1'b1);
        check("rst_left", o_sample_left, '0);
        check("rst_right", o_sample_right, '0);
        check("rst_valid", o_sample_valid, 1'b0);
        check("rst_overrun", o_overrun, 1'b0);
        check("rst_running", o_running, 1'b0);
    endtask

    // Driver: called at a falling edge; inputs apply to the next rising edge.
    task automatic step(input bit valid, input logic [SW-1:0] l, input logic [SW-1:0] r,
                        input bit ready, input bit clr);
        int n;
        n = cyc - e0;
        i_data_valid    = valid;
        i_data_left     = l;
        i_data_right    = r;
        i_sample_ready  = ready;
        i_overrun_clear = clr;
        if (valid && in_run(n)) begin
            if (!slot_full || ready) exp_q.push_back({l, r});
            else drop_now = 1'b1;
        end
        @(negedge i_clock);
    endtask

    // Monitor: just before each rising edge, compare outputs and consume handshakes.
    always @(negedge i_clock) begin
        int n;
        logic [2*SW-1:0] exp_word;
        #3;
        if (!i_reset) begin
            if (clk_on) begin
                n = cyc - e0;
                if (n >= end_n) begin
                    check("bclk_parked", o_codec_bit_clock, 1'b0);
                    check("lrclk_parked", o_codec_lr_clock, 1'b1);
                end else begin
                    check("bclk", o_codec_bit_clock, exp_bclk(n));
                    check("lrclk", o_codec_lr_clock, exp_lr(n));
                end
                check("running", o_running, in_run(n));
            end
            if (mon_on) begin
                check("sample_valid", o_sample_valid, slot_full);
                check("overrun", o_overrun, model_ov);
                if (slot_full && i_sample_ready && exp_q.size() != 0) begin
                    exp_word = exp_q.pop_front();
                    check("sample_words", {o_sample_left, o_sample_right}, exp_word);
                end
                if (drop_now) model_ov = 1'b1;
                else if (i_overrun_clear) model_ov = 1'b0;
                drop_now  = 1'b0;
                slot_full = (exp_q.size() != 0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int nd;
        int frames;
        int guard;
        logic prev_lr;
        logic cur_lr;

        i_reset         = 1'b1;
        i_enable        = 1'b0;
        i_data_valid    = 1'b0;
        i_data_left     = '0;
        i_data_right    = '0;
        i_sample_ready  = 1'b0;
        i_overrun_clear = 1'b0;
        #1;
        check_reset_values();

        @(negedge i_clock);
        @(negedge i_clock);
        i_reset = 1'b0;
        mon_on  = 1'b1;
        repeat (3) step(0, '0, '0, 0, 0);

        // Start-up: settle-time data pulses must be ignored
        i_enable = 1'b1;
        e0       = cyc + 1;
        clk_on   = 1'b1;
        while (cyc - e0 < RUN_EDGE + 4)
            step($urandom_range(0, 7) == 0, SW'($urandom), SW'($urandom), $urandom_range(0, 1) == 1, 0);

        // Directed handoff
        repeat (3) step(0, '0, '0, 1, 0);
        step(1, 24'h123456, 24'hABCDEF, 1, 0);
        step(0, '0, '0, 0, 0);
        step(0, '0, '0, 1, 0);
        step(0, '0, '0, 1, 0);

        // Overrun: keep first, set wins over clear, clear alone
        step(1, 24'h000001, 24'hF00001, 0, 0);
        step(0, '0, '0, 0, 0);
        step(1, 24'h000002, 24'hF00002, 0, 0);
        step(0, '0, '0, 0, 0);
        step(1, 24'h000003, 24'hF00003, 0, 1);
        step(0, '0, '0, 0, 0);
        step(0, '0, '0, 0, 1);
        step(0, '0, '0, 0, 0);
        repeat (2) step(0, '0, '0, 1, 0);

        // Randomised traffic
        repeat (1500)
            step($urandom_range(0, 3) == 0, SW'($urandom), SW'($urandom),
                 $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0);

        // Frame-synchronous source with fixed codec words
        repeat (4) step(0, '0, '0, 1, 0);
        frames  = 0;
        guard   = 0;
        prev_lr = o_codec_lr_clock;
        while (frames < 3 && guard < 4 * FRAME_CYC) begin
            cur_lr = o_codec_lr_clock;
            if (prev_lr && !cur_lr) begin
                step(1, 24'h7FFFFF, 24'h800000, 1, 0);
                frames++;
            end else begin
                step(0, '0, '0, 1, 0);
            end
            prev_lr = cur_lr;
            guard++;
        end
        check("loopback_frames", frames, 3);
        repeat (2) step(0, '0, '0, 1, 0);

        // Shutdown at frame end with a sample left in the buffer
        step(1, 24'h0000AA, 24'h0000BB, 0, 0);
        guard = 0;
        while (exp_bit(cyc - e0) != 10 && guard < FRAME_CYC) begin
            step(0, '0, '0, 0, 0);
            guard++;
        end
        check("reached_bit10", exp_bit(cyc - e0), 10);
        nd         = cyc - e0;
        i_enable   = 1'b0;
        stop_req_n = nd + 1;
        end_n      = BIT_CYC;
        while (end_n < nd + 2) end_n += FRAME_CYC;
        repeat (2) step(0, '0, '0, 0, 0);
        i_enable = 1'b1;
        while (cyc - e0 <= end_n) step(0, '0, '0, 0, 0);
        e0         = e0 + end_n + 1;
        end_n      = NEVER;
        stop_req_n = NEVER;

        // Restart from the parked position; buffered sample still deliverable
        repeat (20) step(0, '0, '0, 0, 0);
        repeat (2) step(0, '0, '0, 1, 0);
        while (cyc - e0 < RUN_EDGE + 10)
            step($urandom_range(0, 7) == 0, SW'($urandom), SW'($urandom), 1, 0);

        // Asynchronous reset with a buffered sample and overrun set
        repeat (2) step(0, '0, '0, 1, 0);
        step(1, 24'h55AA55, 24'hAA55AA, 0, 0);
        step(1, 24'h111111, 24'h222222, 0, 0);
        step(0, '0, '0, 0, 0);
        check("pre_reset_valid", o_sample_valid, 1'b1);
        check("pre_reset_overrun", o_overrun, 1'b1);
        #1;
        i_reset = 1'b1;
        #1;
        check_reset_values();
        mon_on    = 1'b0;
        clk_on    = 1'b0;
        exp_q.delete();
        slot_full = 1'b0;
        model_ov  = 1'b0;
        repeat (3) @(negedge i_clock);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
